// File: rtl/bram_stream_fifo_ctrl.sv
// FIFO controller for an external simple dual-port BRAM.
// Reads are issued ahead of demand into a 2-entry FWFT output buffer.
module bram_stream_fifo_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int NW    = ADDR_WIDTH + 2;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         mem_cnt;
  logic [CW-1:0]         mem_cnt_next;
  logic                  rd_inflight;
  logic [DATA_WIDTH-1:0] obuf [2];
  logic                  obuf_wp;
  logic                  obuf_rp;
  logic [1:0]            buf_cnt;
  logic [1:0]            buf_cnt_next;
  logic [1:0]            occ;
  logic [NW-1:0]         count_next;
  logic                  push;
  logic                  pop;
  logic                  issue;

  assign push           = in_valid & in_ready;
  assign out_valid      = (buf_cnt != 2'd0);
  assign pop            = out_valid & out_ready;
  assign out_data       = obuf[obuf_rp];

  assign mem_wr_en      = push;
  assign mem_write_addr = wr_ptr;
  assign mem_write_data = in_data;
  assign mem_read_addr  = rd_ptr;

  // Slots committed to the buffer (held plus returning from BRAM).
  assign occ   = buf_cnt + {1'b0, rd_inflight};
  assign issue = (mem_cnt != '0) &&
                 (occ < (2'd2 + {1'b0, pop}));

  assign mem_cnt_next = mem_cnt + CW'(push) - CW'(issue);
  assign buf_cnt_next = buf_cnt + {1'b0, rd_inflight}
                      - {1'b0, pop};
  assign count_next   = NW'(mem_cnt_next) + NW'(issue)
                      + NW'(buf_cnt_next);

  // Pointers, occupancy counters and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_cnt     <= '0;
      rd_inflight <= 1'b0;
      buf_cnt     <= 2'd0;
      in_ready    <= 1'b0;
      count       <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (issue)
        rd_ptr <= rd_ptr + 1'b1;
      mem_cnt     <= mem_cnt_next;
      rd_inflight <= issue;
      buf_cnt     <= buf_cnt_next;
      in_ready    <= (mem_cnt_next < CW'(DEPTH));
      count       <= count_next;
    end
  end

  // Output buffer: BRAM data lands at tail, head advances on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obuf[0] <= '0;
      obuf[1] <= '0;
      obuf_wp <= 1'b0;
      obuf_rp <= 1'b0;
    end else begin
      if (rd_inflight) begin
        obuf[obuf_wp] <= mem_read_data;
        obuf_wp       <= ~obuf_wp;
      end
      if (pop)
        obuf_rp <= ~obuf_rp;
    end
  end

endmodule

// File: tb/tb_bram_stream_fifo_ctrl.sv
// Bench for bram_stream_fifo_ctrl with a BRAM model.
// Queue-based reference model plus directed scenarios.
module tb_bram_stream_fifo_ctrl;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW+1:0] count;
  logic          mem_wr_en;
  logic [AW-1:0] mem_write_addr;
  logic [DW-1:0] mem_write_data;
  logic [AW-1:0] mem_read_addr;
  logic [DW-1:0] mem_read_data;

  int checks = 0;
  int errors = 0;

  bram_stream_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .count(count),
    .mem_wr_en(mem_wr_en),
    .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Simple dual-port BRAM, registered read, no bypass.
  logic [DW-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (mem_wr_en)
      bram[mem_write_addr] <= mem_write_data;
    mem_read_data <= bram[mem_read_addr];
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: words held with the edge they were pushed at.
  typedef struct {
    int            t;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  int   edge_n = 0;
  bit   fresh  = 1'b1;

  always @(negedge clk) begin
    bit exp_v;
    int exp_r;
    bit acc;
    bit pp;
    if (!rst_n) begin
      q.delete();
      fresh = 1'b1;
      chk("m_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("m_rst_count", {24'd0, count}, 32'd0);
      chk("m_rst_ready", {31'd0, in_ready}, 32'd0);
    end else begin
      exp_v = (q.size() > 0) && (q[0].t + 2 <= edge_n);
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, exp_v});
      if (exp_v)
        chk("m_out_data", {24'd0, out_data}, {24'd0, q[0].d});
      chk("m_count", {24'd0, count}, q.size());
      if (fresh)
        exp_r = 0;
      else if (q.size() < DEPTH)
        exp_r = 1;
      else if (q.size() == DEPTH + 2)
        exp_r = 0;
      else
        exp_r = -1;
      if (exp_r >= 0)
        chk("m_in_ready", {31'd0, in_ready}, exp_r);
      acc = in_valid && ((exp_r >= 0) ? (exp_r == 1) : in_ready);
      chk("m_wr_en", {31'd0, mem_wr_en}, {31'd0, acc});
      if (acc)
        chk("m_wr_data", {24'd0, mem_write_data}, {24'd0, in_data});
      pp = exp_v && out_ready;
      edge_n++;
      if (pp)
        void'(q.pop_front());
      if (acc)
        q.push_back('{t: edge_n, d: in_data});
      fresh = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int nxt;
    int first;
    int gaps;
    int maxc;
    bit seen;

    // Scenario 1: single word latency
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_count", {24'd0, count}, 32'd0);
    do_reset();
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h11;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_t0_valid", {31'd0, out_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("lat_t1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("lat_t2_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_t2_data", {24'd0, out_data}, 32'h11);
    chk("lat_t2_count", {24'd0, count}, 32'd1);

    // Scenario 2: fill until in_ready drops
    do_reset();
    acc      = 0;
    in_valid = 1'b1;
    in_data  = 8'd0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (in_ready)
        acc++;
      tick();
      in_data = acc[7:0];
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("fill_accepted", acc, 32'd66);
    chk("fill_count", {24'd0, count}, 32'd66);
    chk("fill_in_ready", {31'd0, in_ready}, 32'd0);

    // Scenario 3: drain, consecutive and ordered
    tick();
    out_ready = 1'b1;
    nxt   = 0;
    gaps  = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("drain_data", {24'd0, out_data}, nxt);
        nxt++;
      end else if (nxt > 0 && nxt < 66) begin
        gaps++;
      end
      tick();
    end
    @(negedge clk);
    chk("drain_pops", nxt, 32'd66);
    chk("drain_gaps", gaps, 32'd0);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_count", {24'd0, count}, 32'd0);
    chk("drain_ready", {31'd0, in_ready}, 32'd1);

    // Scenario 4: streaming 0..199
    do_reset();
    out_ready = 1'b1;
    nxt   = 0;
    first = -1;
    gaps  = 0;
    for (int c = 0; c < 210; c++) begin
      in_valid = (c < 200);
      in_data  = c[7:0];
      @(negedge clk);
      if (out_valid) begin
        if (first < 0)
          first = c;
        chk("stream_data", {24'd0, out_data}, nxt);
        nxt++;
      end else if (first >= 0 && nxt < 200) begin
        gaps++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("stream_total", nxt, 32'd200);
    chk("stream_first", first, 32'd3);
    chk("stream_gaps", gaps, 32'd0);

    // Scenario 5: random traffic against the model
    do_reset();
    maxc = 0;
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (int'(count) > maxc)
        maxc = int'(count);
      tick();
    end
    in_valid  = 1'b0;
    chk("rand_count_max", {31'd0, (maxc <= 66)}, 32'd1);
    out_ready = 1'b1;
    repeat (80) tick();
    @(negedge clk);
    chk("rand_drained", {24'd0, count}, 32'd0);

    // Scenario 6: reset mid-stream
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data = 8'h30 + c[7:0];
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("mid_count", {24'd0, count}, 32'd10);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        chk("mid_first_word", {24'd0, out_data}, 32'hA5);
      end
      tick();
    end
    chk("mid_word_seen", {31'd0, seen}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
